mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU control unit's rd/wr strobe interface: the slave end of the fetch, operand-read and store protocol.
- Decodes rd/wr strobe edges, inserts programmable wait states, and performs reads and writes on an internal AWIDTH x DWIDTH array.
- Drives read data with an output-enable and returns ready/err status.
- Sits between the CPU address/data path and program/data storage. Includes a preload port for bench program loading.

Parameters:
AWIDTH, 5, address width; the array holds 2**AWIDTH words
DWIDTH, 8, data word width
WAIT_CYCLES, 1, wait states inserted between a strobe edge and ready (0..15)
ROM_TOP, 0, addresses below ROM_TOP are read-only to bus writes (0 = no ROM region)

Ports:
clk  input  1  clock, rising edge active
rst_  input  1  reset, asynchronous, active-low
addr  input  AWIDTH  bus address, sampled on the strobe rising edge
rd  input  1  read strobe, level, held high for several cycles by the initiator
wr  input  1  write strobe, level
data_in  input  DWIDTH  write data from CPU (valid while wr high)
data_out  output  DWIDTH  registered read data
data_oe  output  1  read data valid / bus drive enable
ready  output  1  access complete; held until strobe drops
err  output  1  one-cycle error pulse
pl_we  input  1  preload write enable
pl_addr  input  AWIDTH  preload address
pl_data  input  DWIDTH  preload data

Behaviour:
- Reset (async, rst_=0): state=IDLE; data_out=0, data_oe=0, ready=0, err=0; rd_q=wr_q=0; wait counter=0. Array contents are not reset.
- Edge detect: rd_rise = rd & ~rd_q; wr_rise = wr & ~wr_q. rd_q and wr_q are registered every cycle.
- FSM states: IDLE, WAIT, RDONE, WDONE, HOLD.
- IDLE:
  - rd_rise & wr_rise, or one strobe rising while the other is already high: err=1 for one cycle, go to HOLD, no access.
  - rd_rise alone: latch addr into addr_q, set dir=read.
  - wr_rise alone: latch addr into addr_q, set dir=write.
  - After latching: if WAIT_CYCLES=0, go directly to RDONE/WDONE; else go to WAIT with cnt=WAIT_CYCLES-1.
- WAIT:
  - The active strobe dropping aborts the access: return to IDLE, no write, no ready, no err.
  - cnt=0: go to RDONE/WDONE. Otherwise cnt decrements.
- Entry to RDONE: data_out<=mem[addr_q], data_oe=1, ready=1.
- Entry to WDONE: mem[addr_q]<=data_in, sampled on the entry edge. ready=1.
  - If addr_q<ROM_TOP: memory is unchanged, err=1 for the entry cycle, ready still asserts so the initiator never hangs.
- RDONE/WDONE: outputs hold while the strobe stays high. When the strobe is low, next state is IDLE and ready=0, data_oe=0. data_out retains its last value.
- Latency: ready is high in the (WAIT_CYCLES+1)th cycle after the cycle in which the strobe rise is sampled.
- HOLD: stays until rd=0 and wr=0, then goes to IDLE. ready and data_oe stay 0.
- New edges arriving outside IDLE are ignored. A new access requires the strobe to drop and rise again.
- Preload: pl_we writes mem[pl_addr]<=pl_data on any cycle in any state and ignores ROM_TOP. If it lands on the same edge and same address as a bus write, the preload wins.
- Read-during-preload of the same address on the RDONE entry edge returns the old data.
- Address width is exact; no wrap or out-of-range cases exist.

Decomposition:
- Shared package cpu_bus_pkg holds the FSM state encodings (IDLE/WAIT/RDONE/WDONE/HOLD), the default AWIDTH/DWIDTH, and the opcode defines shared with the control unit.
- Natural sub-module: strobe_edge_det (registers rd/wr, outputs rd_rise/wr_rise/conflict).
- The array is an inferred reg array inside mem_responder.

Test Plan:
- WAIT_CYCLES=1: preload mem[5]=8'hA7; raise rd with addr=5 and hold 4 cycles -> ready=1, data_oe=1, data_out=8'hA7 in the 2nd cycle after the rise is sampled. Both drop 1 cycle after rd falls.
- Write: wr with addr=9, data_in=8'h3C held 3 cycles -> ready at the same latency. A subsequent read of addr 9 returns 8'h3C; err stays 0.
- ROM_TOP=8: wr with addr=3, data_in=8'hFF on preloaded 8'h11 -> one-cycle err=1, ready=1, mem[3] remains 8'h11.
- Abort: WAIT_CYCLES=3, rd pulse of 2 cycles -> ready and data_oe never assert; FSM back in IDLE, and the next rd completes normally.
- Conflict: rd and wr rise in the same cycle -> err pulse, no memory change, no ready until both are low. A clean rd afterwards succeeds.
- Reset mid-access: assert rst_=0 during WAIT of a write to addr 2 -> all outputs 0 immediately, mem[2] unchanged, and a preloaded value survives reset.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU rd/wr strobe bus.
// Contents:
//   - default address/data widths for bus-attached memories
//   - responder FSM state encoding (IDLE/WAIT/RDONE/WDONE/HOLD)
//   - bus operation codes shared with the CPU control unit
package cpu_bus_pkg;

  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RDONE = 3'd2,
    WDONE = 3'd3,
    HOLD  = 3'd4
  } resp_state_e;

  // Operation kinds the control unit issues on the strobe interface.
  typedef enum logic [1:0] {
    BUS_NOP   = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_OPRD  = 2'd2,
    BUS_STORE = 2'd3
  } bus_op_e;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for the rd/wr strobes.
// Ports:
//   clk, rst_          clock, asynchronous active-low reset
//   rd, wr             level strobes from the initiator
//   rd_rise, wr_rise   strobe went high since the previous cycle
//   conflict           a strobe rose while the other one rose or was already high
module strobe_edge_det (
  input  logic clk,
  input  logic rst_,
  input  logic rd,
  input  logic wr,
  output logic rd_rise,
  output logic wr_rise,
  output logic conflict
);

  logic [1:0] strb;
  logic [1:0] rise;

  assign strb = {wr, rd};

  // One delay flop per strobe; bit 0 is rd, bit 1 is wr.
  for (genvar gi = 0; gi < 2; gi++) begin : g_strb
    logic q_reg;

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        q_reg <= 1'b0;
      end else begin
        q_reg <= strb[gi];
      end
    end

    assign rise[gi] = strb[gi] & ~q_reg;
  end

  assign rd_rise  = rise[0];
  assign wr_rise  = rise[1];
  // Using the raw level of the other strobe also covers simultaneous rises.
  assign conflict = (rise[0] & strb[1]) | (rise[1] & strb[0]);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU rd/wr strobe bus.
// Accepts a read or write on a strobe rising edge, waits WAIT_CYCLES
// cycles, then completes the access on an internal 2**AWIDTH x DWIDTH
// array and raises ready until the strobe drops.
// Ports:
//   clk, rst_                  clock, asynchronous active-low reset
//   addr, rd, wr, data_in      bus request (addr sampled on strobe rise)
//   data_out, data_oe          registered read data and its valid/drive enable
//   ready                      access complete, held until strobe drops
//   err                        one-cycle pulse: strobe conflict or ROM write
//   pl_we, pl_addr, pl_data    preload write port, always active, ignores ROM
module mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int AWIDTH      = DEF_AWIDTH,
  parameter int DWIDTH      = DEF_DWIDTH,
  parameter int WAIT_CYCLES = 1,
  parameter int ROM_TOP     = 0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  output logic              err,
  input  logic              pl_we,
  input  logic [AWIDTH-1:0] pl_addr,
  input  logic [DWIDTH-1:0] pl_data
);

  localparam int DEPTH = 1 << AWIDTH;
  // One extra bit so ROM_TOP may equal DEPTH (whole array read-only).
  localparam logic [AWIDTH:0] ROM_TOP_W = (AWIDTH + 1)'(ROM_TOP);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic rd_rise;
  logic wr_rise;
  logic conflict;

  strobe_edge_det u_edge (
    .clk      (clk),
    .rst_     (rst_),
    .rd       (rd),
    .wr       (wr),
    .rd_rise  (rd_rise),
    .wr_rise  (wr_rise),
    .conflict (conflict)
  );

  resp_state_e       state;
  logic [AWIDTH-1:0] addr_q;
  logic              dir_wr;
  logic [3:0]        cnt;

  logic              strobe_act;
  logic              start;
  logic              enter;
  logic [AWIDTH-1:0] ent_addr;
  logic              ent_wr;
  logic              rom_hit;
  logic              bus_we;

  // Completion ("entry") can happen straight from IDLE when there are no
  // wait states, in which case the address and direction come from the
  // bus rather than from the latched copies.
  always_comb begin
    strobe_act = dir_wr ? wr : rd;
    start      = (state == IDLE) && !conflict && (rd_rise || wr_rise);
    ent_addr   = (state == IDLE) ? addr : addr_q;
    ent_wr     = (state == IDLE) ? wr_rise : dir_wr;
    if (WAIT_CYCLES == 0) begin
      enter = start;
    end else begin
      enter = (state == WAIT) && strobe_act && (cnt == 4'd0);
    end
    rom_hit = {1'b0, ent_addr} < ROM_TOP_W;
    bus_we  = enter && ent_wr && !rom_hit;
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  // No reset on the array. The preload is written second so it wins a
  // same-address collision with a bus write. Bus writes are gated while
  // reset is held so an aborted access cannot leak into memory.
  always_ff @(posedge clk) begin
    if (bus_we && rst_) begin
      mem[ent_addr] <= data_in;
    end
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      data_out <= '0;
      data_oe  <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
      addr_q   <= '0;
      dir_wr   <= 1'b0;
      cnt      <= 4'd0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (conflict) begin
            err   <= 1'b1;
            state <= HOLD;
          end else if (start) begin
            addr_q <= addr;
            dir_wr <= wr_rise;
            cnt    <= CNT_INIT;
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!strobe_act) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        RDONE, WDONE: begin
          if (!strobe_act) begin
            state   <= IDLE;
            ready   <= 1'b0;
            data_oe <= 1'b0;
          end
        end
        HOLD: begin
          if (!rd && !wr) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter) begin
        state <= ent_wr ? WDONE : RDONE;
        ready <= 1'b1;
        if (ent_wr) begin
          // ROM writes still complete with ready so the initiator never hangs.
          err <= rom_hit;
        end else begin
          data_out <= mem[ent_addr];
          data_oe  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances with identical stimulus,
// (WAIT_CYCLES=1, ROM_TOP=8) and (WAIT_CYCLES=3, ROM_TOP=0).
module tb_mem_responder;

  logic       clk;
  logic       rst_;
  logic [4:0] addr;
  logic       rd;
  logic       wr;
  logic [7:0] data_in;
  logic       pl_we;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  logic [1:0] ready_v;
  logic [1:0] oe_v;
  logic [1:0] err_v;
  logic [7:0] dout_v [2];

  int n_chk = 0;
  int n_err = 0;

  // Per-instance configuration and reference memory image.
  int         wc  [2] = '{1, 3};
  int         rom [2] = '{8, 0};
  logic [7:0] mdl [2][32];

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(1), .ROM_TOP(8)) u_dut0 (
    .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout_v[0]), .data_oe(oe_v[0]), .ready(ready_v[0]), .err(err_v[0]),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data)
  );

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_CYCLES(3), .ROM_TOP(0)) u_dut1 (
    .clk(clk), .rst_(rst_), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout_v[1]), .data_oe(oe_v[1]), .ready(ready_v[1]), .err(err_v[1]),
    .pl_we(pl_we), .pl_addr(pl_addr), .pl_data(pl_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_ready"}, k, ready_v[k], 8'd0);
      chk({nm, "_oe"},    k, oe_v[k],    8'd0);
      chk({nm, "_err"},   k, err_v[k],   8'd0);
      chk({nm, "_dout"},  k, dout_v[k],  8'd0);
    end
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a[4:0];
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
    for (int k = 0; k < 2; k++) mdl[k][a] = d;
  endtask

  // One bus access with the strobe high for h cycles. Timing rule: the
  // access completes iff h > WAIT_CYCLES, ready is high for cycles
  // WAIT_CYCLES..h-1 counted from the edge that samples the rise.
  task automatic run_txn(input bit is_wr, input int a, input logic [7:0] d, input int h,
                         input logic [7:0] ed0, input logic [7:0] ed1,
                         input bit ee0, input bit ee1);
    logic [7:0] ed [2];
    bit         ee [2];
    bit         comp;
    ed[0] = ed0; ed[1] = ed1;
    ee[0] = ee0; ee[1] = ee1;
    addr    = a[4:0];
    data_in = d;
    if (is_wr) wr = 1'b1; else rd = 1'b1;
    for (int i = 0; i <= h; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        comp = (i >= wc[k]) && (i < h);
        chk("ready",   k, ready_v[k], {7'd0, comp});
        chk("data_oe", k, oe_v[k],    {7'd0, comp && !is_wr});
        chk("err",     k, err_v[k],   {7'd0, comp && is_wr && ee[k] && (i == wc[k])});
        // Read data appears with ready and is retained after it drops.
        if (!is_wr && (h > wc[k]) && (i >= wc[k]))
          chk("data_out", k, dout_v[k], ed[k]);
      end
      if (i == h - 1) begin
        rd = 1'b0;
        wr = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++)
      if (is_wr && (h > wc[k]) && (a >= rom[k])) mdl[k][a] = d;
    $display("txn %s addr=%0d data=%h hold=%0d", is_wr ? "wr" : "rd", a, d, h);
  endtask

  typedef struct {
    bit         is_wr;
    int         a;
    logic [7:0] d;
    int         h;
    logic [7:0] ed0;
    logic [7:0] ed1;
    bit         ee0;
    bit         ee1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b0,  5, 8'h00, 4, 8'hA7, 8'hA7, 1'b0, 1'b0};
    tbl[1]  = '{1'b1,  9, 8'h3C, 3, 8'h00, 8'h00, 1'b0, 1'b0}; // aborts on wait=3
    tbl[2]  = '{1'b0,  9, 8'h00, 4, 8'h3C, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1,  3, 8'hFF, 3, 8'h00, 8'h00, 1'b1, 1'b0}; // ROM write on dut0
    tbl[4]  = '{1'b0,  3, 8'h00, 5, 8'h11, 8'h11, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 20, 8'h00, 2, 8'h5A, 8'h00, 1'b0, 1'b0}; // 2-cycle pulse
    tbl[6]  = '{1'b0, 20, 8'h00, 5, 8'h5A, 8'h5A, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 12, 8'hC3, 5, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 12, 8'h00, 4, 8'hC3, 8'hC3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0,  5, 8'h00, 1, 8'h00, 8'h00, 1'b0, 1'b0}; // aborts on both
    tbl[10] = '{1'b1,  3, 8'hFF, 5, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b0,  3, 8'h00, 4, 8'h11, 8'hFF, 1'b0, 1'b0};

    rst_ = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_ = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    // Known contents everywhere, then the directed values.
    for (int a = 0; a < 32; a++) preload(a, 8'($urandom));
    preload(5, 8'hA7);
    preload(3, 8'h11);
    preload(9, 8'h00);
    preload(20, 8'h5A);

    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].is_wr, tbl[i].a, tbl[i].d, tbl[i].h,
              tbl[i].ed0, tbl[i].ed1, tbl[i].ee0, tbl[i].ee1);

    // Simultaneous rd/wr rise: one err pulse, no ready, memory untouched.
    addr = 5'd7; data_in = 8'hEE; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("conflict_err",   k, err_v[k],   8'd1);
      chk("conflict_ready", k, ready_v[k], 8'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("conflict_err_pulse", k, err_v[k], 8'd0);
    rd = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk("hold_ready", k, ready_v[k], 8'd0);
    end
    wr = 1'b0;
    @(negedge clk);
    $display("txn conflict addr=7");
    run_txn(1'b0, 7, 8'h00, 5, mdl[0][7], mdl[1][7], 1'b0, 1'b0);

    // Reset while a read is complete: outputs clear without a clock edge.
    addr = 5'd5; rd = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("pre_reset_ready", k, ready_v[k], 8'd1);
      chk("pre_reset_dout",  k, dout_v[k],  8'hA7);
    end
    #2 rst_ = 1'b0;
    #1 chk_idle_outputs("async_reset");
    rd = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    $display("txn reset during read addr=5");

    // Reset during the wait phase of a write: memory must not change.
    preload(2, 8'h77);
    addr = 5'd2; data_in = 8'h55; wr = 1'b1;
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1 chk_idle_outputs("reset_in_wait");
    wr = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    $display("txn reset during write addr=2");
    run_txn(1'b0, 2, 8'h00, 5, 8'h77, 8'h77, 1'b0, 1'b0);
    run_txn(1'b0, 5, 8'h00, 5, 8'hA7, 8'hA7, 1'b0, 1'b0);

    // Randomized accesses against the reference image.
    for (int t = 0; t < 50; t++) begin
      bit         is_wr;
      int         a;
      int         h;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) preload(int'($urandom_range(0, 31)), 8'($urandom));
      is_wr = 1'($urandom_range(0, 1));
      a     = int'($urandom_range(0, 31));
      h     = int'($urandom_range(1, 6));
      d     = 8'($urandom);
      run_txn(is_wr, a, d, h, mdl[0][a], mdl[1][a], a < rom[0], a < rom[1]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
